// File: rtl/control_unit_pipe_pkg.sv
// Shared constants, encodings and the control bundle type for the pipelined RV32
// control unit, plus small decode helpers used by the decoder and the stage register.
package ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam int         ALU_OP_W   = 5;
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_PASSB  = 5'd10;
    localparam logic [4:0] ALU_M_BASE = 5'd16;

    typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_src_e;
    typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2} result_src_e;
    typedef enum logic [1:0] {MW_NONE = 2'd0, MW_BYTE = 2'd1, MW_HALF = 2'd2, MW_WORD = 2'd3} mem_write_e;

    typedef struct packed {
        logic        reg_write, alu_src, alu_a_pc, mem_read, branch, jump, illegal;
        mem_write_e  mem_write;
        result_src_e result_src;
        imm_src_e    imm_src;
        logic [2:0]  funct3;
        logic [4:0]  rd, rs1, rs2;
    } ctrl_bundle_t;

    // Shared ALU selection for OP and OP-IMM; only the register form has SUB.
    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            3'd0:    return (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/control_unit_pipe_if.sv
// Upstream/downstream bundle of the ID/EX control stage: instruction handshake,
// flush, execute backpressure and the registered control outputs.
interface control_unit_pipe_if #(parameter int ALUCTRL_W = 6);
    import ctrl_pkg::*;

    logic                 in_valid, in_ready, flush, ex_ready, out_valid, hazard;
    logic [31:0]          instr;
    logic                 reg_write, alu_src, alu_a_pc, mem_read, branch, jump, illegal;
    mem_write_e           mem_write;
    result_src_e          result_src;
    imm_src_e             imm_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [2:0]           funct3_q;
    logic [4:0]           rd_q, rs1_q, rs2_q;

    modport master (
        output in_valid, instr, flush, ex_ready,
        input  in_ready, out_valid, hazard, reg_write, alu_src, alu_a_pc, mem_read,
               branch, jump, illegal, mem_write, result_src, imm_src, alu_control,
               funct3_q, rd_q, rs1_q, rs2_q
    );

    modport slave (
        input  in_valid, instr, flush, ex_ready,
        output in_ready, out_valid, hazard, reg_write, alu_src, alu_a_pc, mem_read,
               branch, jump, illegal, mem_write, result_src, imm_src, alu_control,
               funct3_q, rd_q, rs1_q, rs2_q
    );
endinterface

// File: rtl/control_unit_pipe_decode.sv
// Purely combinational RV32I(+M) instruction decoder producing the control bundle.
// Illegal encodings leave every control bit cleared apart from illegal itself.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 6,
    parameter bit EN_M      = 1'b1
) (
    input  logic [31:0]          instr_i,
    output ctrl_bundle_t         ctrl_o,
    output logic [ALUCTRL_W-1:0] alu_control_o,
    output logic                 reads_rs2_o
);

    logic [4:0] alu_op;
    logic [2:0] f3;
    logic       alt;

    assign f3  = instr_i[14:12];
    assign alt = instr_i[30];

    always_comb begin
        ctrl_o        = '0;
        alu_op        = ALU_ADD;
        ctrl_o.funct3 = f3;
        ctrl_o.rd     = instr_i[11:7];
        ctrl_o.rs1    = instr_i[19:15];
        ctrl_o.rs2    = instr_i[24:20];
        case (instr_i[6:0])
            OPC_LUI: begin
                ctrl_o.reg_write = 1'b1; ctrl_o.alu_src = 1'b1;
                ctrl_o.imm_src   = IMM_U; alu_op = ALU_PASSB;
            end
            OPC_AUIPC: begin
                ctrl_o.reg_write = 1'b1; ctrl_o.alu_src = 1'b1; ctrl_o.alu_a_pc = 1'b1;
                ctrl_o.imm_src   = IMM_U;
            end
            OPC_JAL: begin
                ctrl_o.reg_write = 1'b1; ctrl_o.alu_src = 1'b1; ctrl_o.alu_a_pc = 1'b1;
                ctrl_o.jump      = 1'b1; ctrl_o.imm_src = IMM_J; ctrl_o.result_src = RES_PC4;
            end
            OPC_JALR: begin
                ctrl_o.reg_write = 1'b1; ctrl_o.alu_src = 1'b1; ctrl_o.jump = 1'b1;
                ctrl_o.imm_src   = IMM_I; ctrl_o.result_src = RES_PC4;
            end
            OPC_BRANCH: begin
                ctrl_o.branch = 1'b1; ctrl_o.imm_src = IMM_B; alu_op = ALU_SUB;
            end
            OPC_LOAD: begin
                ctrl_o.reg_write  = 1'b1; ctrl_o.alu_src = 1'b1; ctrl_o.mem_read = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OPC_STORE: begin
                ctrl_o.alu_src   = 1'b1; ctrl_o.imm_src = IMM_S;
                ctrl_o.mem_write = mem_write_e'(instr_i[13:12] + 2'd1);
            end
            OPC_OP_IMM: begin
                ctrl_o.reg_write = 1'b1; ctrl_o.alu_src = 1'b1;
                alu_op = base_alu(f3, alt, 1'b0);
            end
            OPC_OP: begin
                if (instr_i[31:25] == F7_MULDIV) begin
                    if (EN_M) begin
                        ctrl_o.reg_write = 1'b1;
                        alu_op = ALU_M_BASE | {2'b00, f3};
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end else begin
                    ctrl_o.reg_write = 1'b1;
                    alu_op = base_alu(f3, alt, 1'b1);
                end
            end
            default: ctrl_o.illegal = 1'b1;
        endcase
    end

    assign alu_control_o = ALUCTRL_W'(alu_op);
    assign reads_rs2_o   = reads_rs2(instr_i[6:0]);

endmodule

// File: rtl/control_unit_pipe.sv
// ID/EX control stage: decodes the incoming instruction, registers the bundle under
// a valid/ready handshake with flush, and inserts one bubble on a load-use hazard.
module control_unit_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 6,   // must be at least 5 to hold the RV32M codes
    parameter bit EN_M      = 1'b1,
    parameter bit EN_HAZARD = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    control_unit_pipe_if.slave bus
);

    ctrl_bundle_t         dec, bundle_q, bundle_d;
    logic [ALUCTRL_W-1:0] dec_alu, alu_q, alu_d;
    logic                 valid_q, valid_d;
    logic                 dec_reads_rs2, rs_match, hazard, in_ready;

    ctrl_decode #(.ALUCTRL_W(ALUCTRL_W), .EN_M(EN_M)) u_decode (
        .instr_i       (bus.instr),
        .ctrl_o        (dec),
        .alu_control_o (dec_alu),
        .reads_rs2_o   (dec_reads_rs2)
    );

    assign rs_match = (bundle_q.rd == dec.rs1) || (dec_reads_rs2 && (bundle_q.rd == dec.rs2));
    assign hazard   = EN_HAZARD && valid_q && bundle_q.mem_read && (bundle_q.rd != 5'd0)
                      && rs_match && bus.in_valid;
    assign in_ready = (!valid_q || bus.ex_ready) && !hazard;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        alu_d    = alu_q;
        // A flush drops any same-cycle instruction even though in_ready may be high.
        if (bus.flush || (hazard && bus.ex_ready)) begin
            valid_d  = 1'b0;
            bundle_d = '0;
            alu_d    = ALUCTRL_W'(ALU_ADD);
        end else if (bus.in_valid && in_ready) begin
            valid_d  = 1'b1;
            bundle_d = dec;
            alu_d    = dec_alu;
        end else if (valid_q && bus.ex_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            alu_q    <= ALUCTRL_W'(ALU_ADD);
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            alu_q    <= alu_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.hazard      = hazard;
    assign bus.out_valid   = valid_q;
    assign bus.reg_write   = bundle_q.reg_write;
    assign bus.alu_src     = bundle_q.alu_src;
    assign bus.alu_a_pc    = bundle_q.alu_a_pc;
    assign bus.mem_read    = bundle_q.mem_read;
    assign bus.branch      = bundle_q.branch;
    assign bus.jump        = bundle_q.jump;
    assign bus.illegal     = bundle_q.illegal;
    assign bus.mem_write   = bundle_q.mem_write;
    assign bus.result_src  = bundle_q.result_src;
    assign bus.imm_src     = bundle_q.imm_src;
    assign bus.alu_control = alu_q;
    assign bus.funct3_q    = bundle_q.funct3;
    assign bus.rd_q        = bundle_q.rd;
    assign bus.rs1_q       = bundle_q.rs1;
    assign bus.rs2_q       = bundle_q.rs2;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Self-checking bench: two stages (RV32M on and off) driven in lockstep with directed
// and random instructions, compared every cycle against a behavioural model.
module tb_control_unit_pipe;

    localparam logic [31:0] I_ADD3  = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] I_LW5   = 32'h0000A283;  // lw  x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00228333;  // add x6,x5,x2
    localparam logic [31:0] I_MUL7  = 32'h022083B3;  // mul x7,x1,x2
    localparam logic [31:0] I_SB    = 32'h00208023;  // sb  x2,0(x1)
    localparam logic [31:0] I_SW    = 32'h0020A023;  // sw  x2,0(x1)
    localparam logic [31:0] I_LW0   = 32'h0000A003;  // lw  x0,0(x1)
    localparam logic [31:0] I_ADDX0 = 32'h00200333;  // add x6,x0,x2

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    control_unit_pipe_if #(.ALUCTRL_W(6)) bus_m ();
    control_unit_pipe_if #(.ALUCTRL_W(6)) bus_nm ();

    control_unit_pipe #(.ALUCTRL_W(6), .EN_M(1'b1), .EN_HAZARD(1'b1)) dut_m (
        .clk(clk), .rst(rst), .bus(bus_m));
    control_unit_pipe #(.ALUCTRL_W(6), .EN_M(1'b0), .EN_HAZARD(1'b1)) dut_nm (
        .clk(clk), .rst(rst), .bus(bus_nm));

    // {rw,alu_src,a_pc,mem_read,branch,jump,illegal,mem_write,result_src,imm_src,alu,f3,rd,rs1,rs2}
    wire [37:0] obs_b_m  = {bus_m.reg_write, bus_m.alu_src, bus_m.alu_a_pc, bus_m.mem_read,
                            bus_m.branch, bus_m.jump, bus_m.illegal, bus_m.mem_write,
                            bus_m.result_src, bus_m.imm_src, bus_m.alu_control,
                            bus_m.funct3_q, bus_m.rd_q, bus_m.rs1_q, bus_m.rs2_q};
    wire [37:0] obs_b_nm = {bus_nm.reg_write, bus_nm.alu_src, bus_nm.alu_a_pc, bus_nm.mem_read,
                            bus_nm.branch, bus_nm.jump, bus_nm.illegal, bus_nm.mem_write,
                            bus_nm.result_src, bus_nm.imm_src, bus_nm.alu_control,
                            bus_nm.funct3_q, bus_nm.rd_q, bus_nm.rs1_q, bus_nm.rs2_q};

    int          n_cmp = 0;
    int          n_err = 0;
    int          step_no = 0;
    bit          exp_valid;
    logic [37:0] exp_b_m, exp_b_nm, saved_b;
    logic        last_hz, last_rdy;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    // Expected bundle straight from the instruction-set rules.
    function automatic logic [37:0] model_bundle(input logic [31:0] ins, input bit en_m);
        int alu_of_f3 [8];
        bit rw, asrc, apc, mrd, br, jmp, ill;
        int mw, rs, imm, alu, f3;
        alu_of_f3 = '{0, 2, 3, 4, 5, 6, 8, 9};
        {rw, asrc, apc, mrd, br, jmp, ill} = '0;
        mw = 0; rs = 0; imm = 0; alu = 0;
        f3 = int'(ins[14:12]);
        case (ins[6:0])
            7'h37: begin rw = 1; asrc = 1; imm = 4; alu = 10; end
            7'h17: begin rw = 1; asrc = 1; apc = 1; imm = 4; end
            7'h6F: begin rw = 1; asrc = 1; apc = 1; jmp = 1; imm = 3; rs = 2; end
            7'h67: begin rw = 1; asrc = 1; jmp = 1; rs = 2; end
            7'h63: begin br = 1; imm = 2; alu = 1; end
            7'h03: begin rw = 1; asrc = 1; mrd = 1; rs = 1; end
            7'h23: begin asrc = 1; imm = 1; mw = (f3 % 4 + 1) % 4; end
            7'h13: begin rw = 1; asrc = 1; alu = (f3 == 5 && ins[30]) ? 7 : alu_of_f3[f3]; end
            7'h33: begin
                if (ins[31:25] == 7'd1) begin
                    if (en_m) begin rw = 1; alu = 16 + f3; end
                    else ill = 1;
                end else begin
                    rw = 1;
                    if (f3 == 0 && ins[30]) alu = 1;
                    else if (f3 == 5 && ins[30]) alu = 7;
                    else alu = alu_of_f3[f3];
                end
            end
            default: ill = 1;
        endcase
        return {rw, asrc, apc, mrd, br, jmp, ill, 2'(mw), 2'(rs), 3'(imm), 6'(alu),
                ins[14:12], ins[11:7], ins[19:15], ins[24:20]};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        int k;
        k   = $urandom_range(0, 11);
        f3  = 3'($urandom_range(0, 7));
        f7  = 7'($urandom_range(0, 127));
        case (k)
            0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
            4: opc = 7'h63;  5, 6, 7: opc = 7'h03;
            8: begin opc = 7'h23; f3 = 3'($urandom_range(0, 2)); end
            9: begin opc = 7'h13; if (f3 == 3'd5) f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            10: begin
                opc = 7'h33;
                case ($urandom_range(0, 2))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    default: f7 = 7'h01;
                endcase
            end
            default: opc = $urandom_range(0, 1) ? 7'h7F : 7'h0B;
        endcase
        return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), f3,
                5'($urandom_range(0, 3)), opc};
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input bit fl, input bit er);
        bus_m.in_valid  = v;  bus_m.instr  = ins; bus_m.flush  = fl; bus_m.ex_ready  = er;
        bus_nm.in_valid = v;  bus_nm.instr = ins; bus_nm.flush = fl; bus_nm.ex_ready = er;
    endtask

    // One clock: drive at edge+1, check handshake, advance, check the registered stage.
    task automatic step(input bit v, input logic [31:0] ins, input bit fl, input bit er);
        bit hz, rdy, hit;
        logic [4:0] rdq;
        logic [6:0] opc;
        step_no++;
        drive(v, ins, fl, er);
        #1;
        rdq = exp_b_m[14:10];
        opc = ins[6:0];
        hit = (rdq == ins[19:15]) ||
              ((opc == 7'h33 || opc == 7'h23 || opc == 7'h63) && rdq == ins[24:20]);
        hz  = exp_valid && exp_b_m[34] && (rdq != 5'd0) && v && hit;
        rdy = (!exp_valid || er) && !hz;
        last_hz  = bus_m.hazard;
        last_rdy = bus_m.in_ready;
        check_eq("hazard_m",    64'(bus_m.hazard),    64'(hz));
        check_eq("in_ready_m",  64'(bus_m.in_ready),  64'(rdy));
        check_eq("hazard_nm",   64'(bus_nm.hazard),   64'(hz));
        check_eq("in_ready_nm", 64'(bus_nm.in_ready), 64'(rdy));
        $display("step %0d v=%0b instr=%08h flush=%0b ex_ready=%0b hazard=%0b in_ready=%0b",
                 step_no, v, ins, fl, er, bus_m.hazard, bus_m.in_ready);
        @(posedge clk);
        #1;
        if (fl || (hz && er)) begin
            exp_valid = 1'b0; exp_b_m = '0; exp_b_nm = '0;
        end else if (v && rdy) begin
            exp_valid = 1'b1;
            exp_b_m   = model_bundle(ins, 1'b1);
            exp_b_nm  = model_bundle(ins, 1'b0);
        end else if (exp_valid && er) begin
            exp_valid = 1'b0;
        end
        check_eq("out_valid_m",  64'(bus_m.out_valid),  64'(exp_valid));
        check_eq("bundle_m",     64'(obs_b_m),          64'(exp_b_m));
        check_eq("out_valid_nm", 64'(bus_nm.out_valid), 64'(exp_valid));
        check_eq("bundle_nm",    64'(obs_b_nm),         64'(exp_b_nm));
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        exp_valid = 1'b0; exp_b_m = '0; exp_b_nm = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid",  64'(bus_m.out_valid), 64'd0);
        check_eq("rst_bundle", 64'(obs_b_m),         64'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_in_ready", 64'(bus_m.in_ready), 64'd1);
        check_eq("rel_hazard",   64'(bus_m.hazard),   64'd0);
        check_eq("rel_valid",    64'(bus_m.out_valid), 64'd0);

        step(1'b1, I_ADD3, 1'b0, 1'b1);
        check_eq("add_valid", 64'(bus_m.out_valid),   64'd1);
        check_eq("add_rw",    64'(bus_m.reg_write),   64'd1);
        check_eq("add_alu",   64'(bus_m.alu_control), 64'd0);
        check_eq("add_rd",    64'(bus_m.rd_q),        64'd3);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        step(1'b1, I_LW5, 1'b0, 1'b1);
        step(1'b1, I_ADD6, 1'b0, 1'b1);
        check_eq("lu_hazard", 64'(last_hz),  64'd1);
        check_eq("lu_ready",  64'(last_rdy), 64'd0);
        check_eq("lu_bubble", 64'(bus_m.out_valid), 64'd0);
        step(1'b1, I_ADD6, 1'b0, 1'b1);
        check_eq("lu_clear",  64'(last_hz),  64'd0);
        check_eq("lu_issue",  64'(bus_m.out_valid), 64'd1);
        check_eq("lu_rd",     64'(bus_m.rd_q), 64'd6);

        step(1'b1, I_MUL7, 1'b0, 1'b1);
        check_eq("mul_alu_m",  64'(bus_m.alu_control), 64'd16);
        check_eq("mul_ill_m",  64'(bus_m.illegal),     64'd0);
        check_eq("mul_ill_nm", 64'(bus_nm.illegal),    64'd1);
        check_eq("mul_rw_nm",  64'(bus_nm.reg_write),  64'd0);
        check_eq("mul_vld_nm", 64'(bus_nm.out_valid),  64'd1);

        step(1'b1, I_SB, 1'b0, 1'b1);
        check_eq("sb_mw", 64'(bus_m.mem_write), 64'd1);
        saved_b = obs_b_m;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, I_SW, 1'b0, 1'b0);
            check_eq("bp_ready",  64'(last_rdy), 64'd0);
            check_eq("bp_stable", 64'(obs_b_m),  64'(saved_b));
        end
        step(1'b1, I_SW, 1'b0, 1'b1);
        check_eq("sw_mw", 64'(bus_m.mem_write), 64'd3);

        step(1'b1, I_ADD3, 1'b1, 1'b1);
        check_eq("flush_valid",  64'(bus_m.out_valid), 64'd0);
        check_eq("flush_bundle", 64'(obs_b_m),         64'd0);

        step(1'b1, I_LW0, 1'b0, 1'b1);
        step(1'b1, I_ADDX0, 1'b0, 1'b1);
        check_eq("x0_hazard", 64'(last_hz),  64'd0);
        check_eq("x0_ready",  64'(last_rdy), 64'd1);
        check_eq("x0_rd",     64'(bus_m.rd_q), 64'd6);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) < 7);

        step(1'b1, I_LW5, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_valid",  64'(bus_m.out_valid), 64'd0);
        check_eq("arst_bundle", 64'(obs_b_m),         64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        exp_valid = 1'b0; exp_b_m = '0; exp_b_nm = '0;
        @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 9) < 8, rand_instr(), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 9) < 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit_pipe.md
# control_unit_pipe

Parametrised successor to the single-cycle control unit for the pipelined RV32 core. It decodes a 32-bit instruction into the control bundle, registers it as the ID/EX control stage under a valid/ready handshake, and supports flush. It also detects load-use hazards and inserts a bubble, with optional RV32M decode. It sits between the IF/ID register and the execute stage.

## Interface
- `ALUCTRL_W`, default 6: width of `alu_control`. Must be ≥5.
- `EN_M`, default 1: decode RV32M (opcode 0110011, funct7 0000001). When 0, these instructions are illegal.
- `EN_HAZARD`, default 1: enable load-use stall. When 0, `hazard` is tied to 0.
- `clk` in 1: clock. Rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: `instr` is valid.
- `in_ready` out 1: instruction accepted this cycle.
- `instr` in 32: instruction from IF/ID.
- `flush` in 1: kill the registered stage (branch taken or jump).
- `ex_ready` in 1: execute stage accepts the output.
- `out_valid` out 1: output bundle is valid.
- `reg_write`, `alu_src`, `alu_a_pc`, `mem_read`, `branch`, `jump`, `illegal` out 1 each: registered control bits.
- `mem_write` out 2: store size. 00 none, 01 byte, 10 half, 11 word.
- `result_src` out 2: result select. 0 ALU, 1 memory, 2 PC+4.
- `imm_src` out 3: immediate format. 0 I, 1 S, 2 B, 3 J, 4 U.
- `alu_control` out `ALUCTRL_W`: ALU operation.
- `funct3_q` out 3, `rd_q` out 5, `rs1_q` out 5, `rs2_q` out 5: registered instruction fields.
- `hazard` out 1: load-use stall is active this cycle.

## Operation
- **ALU codes:** 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - RV32M codes are 16+funct3: MUL=16 … REMU=23.
  - Loads, stores, JAL, JALR and AUIPC use ADD. Branches use SUB. LUI uses PASSB.
- **Field rules:**
  - I-type SRAI/SRLI are distinguished by instr[30].
  - R-type SUB and SRA are distinguished by instr[30].
  - `alu_a_pc` is 1 for AUIPC and JAL.
  - `mem_write` = funct3[1:0]+1 for stores.
- **Illegal instructions:** an unknown opcode, or RV32M with `EN_M`=0, sets `illegal`=1. It forces `reg_write`=0, `mem_write`=0, `mem_read`=0, `branch`=0 and `jump`=0, and `out_valid` is still asserted.
- **Load-use hazard:** `hazard` = `out_valid` & `mem_read` & (`rd_q`≠0) & (`rd_q`==instr rs1, or `rd_q`==instr rs2 when the incoming instruction reads rs2, i.e. R/S/B type) & `in_valid`.
- **Ready:** `in_ready` = (!`out_valid` | `ex_ready`) & !`hazard`. This is combinational.
- **Stage register update, in priority order:**
  1. `flush`: `out_valid`←0, bundle cleared.
  2. `hazard` & `ex_ready`: bubble. `out_valid`←0, bundle cleared.
  3. `in_valid` & `in_ready`: load the decoded bundle, `out_valid`←1.
  4. `out_valid` & `ex_ready`: drain. `out_valid`←0.
  5. Otherwise hold.
- **Cleared bundle:** all outputs 0. `alu_control`=ADD.
- **Flush with `in_valid` in the same cycle:** the instruction is dropped even though `in_ready` may read 1. Upstream flushes IF/ID in the same cycle.

## Timing
- Reset values: every registered output is 0 and `out_valid`=0. After reset, `in_ready`=1 and `hazard`=0.
- Latency: one cycle from an accepted instruction to `out_valid`.
- Throughput: one instruction per cycle while `ex_ready`=1 and there is no hazard.
- A load-use hazard costs exactly one bubble cycle. In the following cycle the load has drained, the hazard clears and the dependent instruction is accepted.
- Backpressure: while `ex_ready`=0 and `out_valid`=1, all outputs hold stable and `in_ready`=0.
- Reset mid-operation: outputs clear immediately and asynchronously. There is no partial bundle after release.
- `rd_q`=x0 never raises a hazard.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants;
  - ALU code constants;
  - `imm_src`, `result_src` and `mem_write` encodings;
  - a packed struct typedef for the control bundle.
- Sub-module `ctrl_decode`: a purely combinational instruction-to-bundle decoder, parametrised by `EN_M` and `ALUCTRL_W`.
- Top level: the stage register, hazard compare and handshake.

## Test plan
- **Reset and ADD:** hold `rst`=0, then release. Feed `add x3,x1,x2` (0x002081B3) with `ex_ready`=1. Next cycle: `out_valid`=1, `reg_write`=1, `alu_control`=0, `rd_q`=3.
- **Load-use:** feed `lw x5,0(x1)`, then `add x6,x5,x2`. `hazard`=1 and `in_ready`=0 for one cycle, one bubble (`out_valid`=0), then the add is issued with `rd_q`=6.
- **RV32M:** feed `mul x7,x1,x2` (0x022083B3). With `EN_M`=1: `alu_control`=16. With `EN_M`=0: `illegal`=1 and `reg_write`=0.
- **Backpressure:** hold `ex_ready`=0 for 3 cycles with `in_valid`=1. Outputs stay stable, `in_ready`=0, and no instruction is lost or duplicated.
- **Flush:** assert `flush` with a valid bundle and `in_valid`=1. Next cycle `out_valid`=0 and the bundle is cleared.
- **Loads and stores:** `sb` gives `mem_write`=01 and `sw` gives 11. `lw` with `rd`=x0 followed by a dependent `add` gives no hazard.
